dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 35 +++
 rtl/dmem_responder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

   localparam int DEPTH_WORDS_DEF = 256;
   localparam int WAIT_CYCLES_DEF = 2;
   localparam int CNT_W           = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Misaligned word address, or any bit set above the word-index range.
   function automatic logic addr_fault(input logic [31:0] addr, input int idx_w);
      logic [31:0] hi;
      hi = addr >> (idx_w + 2);
      return (addr[1:0] != 2'b00) || (hi != 32'h0);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with a synchronous byte-write port and a synchronous read port.
module dmem_array #(
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic [3:0]       wr_be_i,
   input  logic [31:0]      wr_data_i,
   input  logic             rd_en_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [31:0]      rd_data_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rd_data_q;

   // Contents are deliberately not reset so data survives a controller reset.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be_i[b]) begin
               mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
            end
         end
      end
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_idx_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: accepts one request, waits WAIT_CYCLES, responds for one cycle.
//   state   | meaning
//   IDLE    | ready for a request
//   WAIT    | request latched, counting wait states down
//   RESP    | response valid this cycle; commit/capture happened on entry
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_stall
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_INIT =
      (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

   logic [1:0]       rst_sync_q;
   logic             rst_n_sync;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             we_q;
   logic [31:0]      addr_q;
   logic [3:0]       be_q;
   logic [31:0]      wdata_q;
   logic [31:0]      hold_q;

   logic             accept;
   logic             enter_resp;
   logic             src_we;
   logic [31:0]      src_addr;
   logic [3:0]       src_be;
   logic [31:0]      src_wdata;
   logic             src_fault;
   logic             arr_wr_en;
   logic             arr_rd_en;
   logic [31:0]      arr_rdata;

   // Assertion is immediate; release reaches the rest of the block two edges later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n_sync = rst_sync_q[1];
   assign accept     = req_valid && req_ready;

   always_ff @(posedge clk or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      req_ready  = (state_q == ST_IDLE) && rst_n_sync;
      resp_valid = (state_q == ST_RESP);
      resp_err   = 1'b0;
      resp_rdata = hold_q;
      if (state_q == ST_RESP) begin
         resp_err = addr_fault(addr_q, IDX_W);
         if (resp_err) begin
            resp_rdata = 32'h0000_0000;
         end else if (we_q) begin
            resp_rdata = hold_q;
         end else begin
            resp_rdata = arr_rdata;
         end
      end
   end

   assign mem_stall = req_valid && !resp_valid;

   // With zero wait states RESP is entered straight from IDLE, so the live request drives the array.
   assign src_we    = (state_q == ST_IDLE) ? req_we    : we_q;
   assign src_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
   assign src_be    = (state_q == ST_IDLE) ? req_be    : be_q;
   assign src_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
   assign src_fault = addr_fault(src_addr, IDX_W);

   assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP) && rst_n_sync;
   assign arr_wr_en  = enter_resp && src_we && !src_fault;
   assign arr_rd_en  = enter_resp && !src_we;

   always_ff @(posedge clk or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         hold_q  <= '0;
      end else begin
         if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            be_q    <= req_be;
            wdata_q <= req_wdata;
         end
         if (state_q == ST_RESP) begin
            hold_q <= resp_rdata;
         end
      end
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk       (clk),
      .wr_en_i   (arr_wr_en),
      .wr_idx_i  (src_addr[IDX_W+1:2]),
      .wr_be_i   (src_be),
      .wr_data_i (src_wdata),
      .rd_en_i   (arr_rd_en),
      .rd_idx_i  (src_addr[IDX_W+1:2]),
      .rd_data_o (arr_rdata)
   );

endmodule
